// File: rtl/program_stream_loader.sv
// Byte-serial program loader: unframes a byte-stuffed stream (START ... END), packs bytes into
// WORD_W-bit words, writes them to sequential instruction-memory addresses and gates CPU reset.
module program_stream_loader #(
  parameter int         WORD_W     = 32,
  parameter int         ADDR_W     = 8,
  parameter int         MAX_WORDS  = 64,
  parameter int         BIG_ENDIAN = 0,
  parameter logic [7:0] START_BYTE = 8'hFE,
  parameter logic [7:0] END_BYTE   = 8'hFF,
  parameter logic [7:0] ESC_BYTE   = 8'hFD
) (
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  output logic              cpu_run_o,
  output logic              load_done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_count_o
);

  localparam int               BPW       = WORD_W / 8;
  localparam int               IDX_W     = (BPW > 1) ? $clog2(BPW) : 1;
  localparam bit               BE        = (BIG_ENDIAN != 0);
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(BPW - 1);
  localparam logic [ADDR_W:0]  MAX_CNT   = (ADDR_W + 1)'(MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ESC,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  byte_idx;
  logic [WORD_W-1:0] word_buf;
  logic [WORD_W-1:0] merged;
  logic [WORD_W-1:0] wr_data;
  logic              start_frame;
  logic              push_byte;
  logic              end_frame;
  logic              word_ready;
  logic              full;

  // Current assembly word with the incoming byte dropped into lane byte_idx.
  always_comb begin
    merged = word_buf;
    for (int l = 0; l < BPW; l++) begin
      if (IDX_W'(l) == byte_idx) begin
        if (BE) merged[WORD_W-8-8*l +: 8] = byte_i;
        else    merged[8*l +: 8]          = byte_i;
      end
    end
  end

  // NOTE: every signal of an always_comb gets a default first, otherwise a path that
  // skips an assignment infers a latch.
  always_comb begin
    state_n     = state;
    start_frame = 1'b0;
    push_byte   = 1'b0;
    end_frame   = 1'b0;
    if (byte_valid_i) begin
      case (state)
        IDLE, DONE: begin
          if (byte_i == START_BYTE) begin
            start_frame = 1'b1;
            state_n     = LOAD;
          end
        end
        LOAD: begin
          if (byte_i == START_BYTE) begin
            start_frame = 1'b1;
          end else if (byte_i == ESC_BYTE) begin
            state_n = ESC;
          end else if (byte_i == END_BYTE) begin
            end_frame = 1'b1;
            state_n   = DONE;
          end else begin
            push_byte = 1'b1;
          end
        end
        ESC: begin
          push_byte = 1'b1;
          state_n   = LOAD;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // A word is due either when the last lane fills or when END arrives with a partial word.
  always_comb begin
    word_ready = (push_byte && (byte_idx == LAST_LANE)) || (end_frame && (byte_idx != '0));
    wr_data    = push_byte ? merged : word_buf;
    full       = (word_count_o == MAX_CNT);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx     <= '0;
      word_buf     <= '0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      cpu_run_o    <= 1'b0;
      load_done_o  <= 1'b0;
      err_o        <= 1'b0;
      word_count_o <= '0;
    end else begin
      mem_we_o <= 1'b0;
      if (start_frame) begin
        byte_idx     <= '0;
        word_buf     <= '0;
        word_count_o <= '0;
        err_o        <= 1'b0;
        load_done_o  <= 1'b0;
        cpu_run_o    <= 1'b0;
      end else begin
        if (push_byte) begin
          if (byte_idx == LAST_LANE) begin
            byte_idx <= '0;
            word_buf <= '0;
          end else begin
            byte_idx <= byte_idx + IDX_W'(1);
            word_buf <= merged;
          end
        end
        if (end_frame) begin
          load_done_o <= 1'b1;
          cpu_run_o   <= 1'b1;
          byte_idx    <= '0;
          word_buf    <= '0;
          if (byte_idx != '0) err_o <= 1'b1;
        end
        // Words beyond MAX_WORDS are dropped but flagged.
        if (word_ready) begin
          if (full) begin
            err_o <= 1'b1;
          end else begin
            mem_we_o     <= 1'b1;
            mem_addr_o   <= word_count_o[ADDR_W-1:0];
            mem_wdata_o  <= wr_data;
            word_count_o <= word_count_o + (ADDR_W + 1)'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_program_stream_loader.sv
// Bench for program_stream_loader: three configurations share one byte stream and are checked
// against a frame-level reference model, plus table vectors and hand-written corner sequences.
`timescale 1ns/1ps
module tb_program_stream_loader;

  typedef logic [7:0] byte_t;
  typedef struct {
    int     addr;
    longint data;
  } wr_t;
  typedef struct {
    byte_t  bytes [16];
    int     len;
    int     dut;
    int     n_writes;
    int     last_addr;
    longint last_data;
    bit     err;
    int     count;
    bit     done;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic byte_valid = 1'b0;
  byte_t byte_in = 8'h00;

  logic        we0, run0, done0, err0;
  logic [7:0]  addr0;
  logic [31:0] wdata0;
  logic [8:0]  cnt0;
  logic        we1, run1, done1, err1;
  logic [7:0]  addr1;
  logic [31:0] wdata1;
  logic [8:0]  cnt1;
  logic        we2, run2, done2, err2;
  logic [7:0]  addr2;
  logic [15:0] wdata2;
  logic [8:0]  cnt2;

  always #5 clk = ~clk;

  program_stream_loader dut0 (
    .clk_i(clk), .reset_n(reset_n), .byte_valid_i(byte_valid), .byte_i(byte_in),
    .mem_we_o(we0), .mem_addr_o(addr0), .mem_wdata_o(wdata0), .cpu_run_o(run0),
    .load_done_o(done0), .err_o(err0), .word_count_o(cnt0));

  program_stream_loader #(.MAX_WORDS(2)) dut1 (
    .clk_i(clk), .reset_n(reset_n), .byte_valid_i(byte_valid), .byte_i(byte_in),
    .mem_we_o(we1), .mem_addr_o(addr1), .mem_wdata_o(wdata1), .cpu_run_o(run1),
    .load_done_o(done1), .err_o(err1), .word_count_o(cnt1));

  program_stream_loader #(.WORD_W(16), .BIG_ENDIAN(1)) dut2 (
    .clk_i(clk), .reset_n(reset_n), .byte_valid_i(byte_valid), .byte_i(byte_in),
    .mem_we_o(we2), .mem_addr_o(addr2), .mem_wdata_o(wdata2), .cpu_run_o(run2),
    .load_done_o(done2), .err_o(err2), .word_count_o(cnt2));

  int bpw_t  [3] = '{4, 4, 2};
  int maxw_t [3] = '{64, 2, 64};
  bit be_t   [3] = '{1'b0, 1'b0, 1'b1};

  int    n_checks = 0;
  int    n_fail = 0;
  byte_t hist[$];
  wr_t   got0[$], got1[$], got2[$];
  int    base0 = 0, base1 = 0, base2 = 0;
  vec_t  vecs[$];

  wr_t   m_w[$];
  bit    m_err, m_done;
  int    m_cnt;

  // Strobe capture, mid-cycle.
  always @(negedge clk) begin
    wr_t w;
    if (we0) begin w.addr = int'(addr0); w.data = longint'(wdata0); got0.push_back(w); end
    if (we1) begin w.addr = int'(addr1); w.data = longint'(wdata1); got1.push_back(w); end
    if (we2) begin w.addr = int'(addr2); w.data = longint'(wdata2); got2.push_back(w); end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Frame-level reference: a frame's payload is cut into words; the first maxw are written.
  function automatic void close_frame(input byte_t d[$], input bit ended, input int bpw,
                                      input int maxw, input bit be);
    int nfull = d.size() / bpw;
    int part  = (ended && (d.size() % bpw != 0)) ? 1 : 0;
    for (int k = 0; k < nfull + part; k++) begin
      if (k < maxw) begin
        wr_t    w;
        longint word = 0;
        for (int j = 0; j < bpw; j++) begin
          int     p = k * bpw + j;
          longint v = (p < d.size()) ? longint'(d[p]) : 64'd0;
          word |= v << (be ? 8 * (bpw - 1 - j) : 8 * j);
        end
        w.addr = k;
        w.data = word;
        m_w.push_back(w);
      end
    end
    m_err  = (nfull > maxw) || (part != 0);
    m_cnt  = (nfull + part < maxw) ? nfull + part : maxw;
    m_done = ended;
  endfunction

  function automatic void model(input int bpw, input int maxw, input bit be);
    byte_t d[$];
    bit    open = 1'b0;
    bit    esc = 1'b0;
    m_w = {};
    m_err = 1'b0;
    m_cnt = 0;
    m_done = 1'b0;
    foreach (hist[i]) begin
      byte_t b = hist[i];
      if (!open) begin
        if (b == 8'hFE) begin open = 1'b1; d = {}; end
      end else if (esc) begin
        d.push_back(b);
        esc = 1'b0;
      end else if (b == 8'hFE) begin
        close_frame(d, 1'b0, bpw, maxw, be);
        d = {};
      end else if (b == 8'hFD) begin
        esc = 1'b1;
      end else if (b == 8'hFF) begin
        close_frame(d, 1'b1, bpw, maxw, be);
        open = 1'b0;
      end else begin
        d.push_back(b);
      end
    end
    if (open) close_frame(d, 1'b0, bpw, maxw, be);
  endfunction

  task automatic get_q(input int i, output wr_t q[$]);
    wr_t src[$];
    int  base;
    case (i)
      0:       begin src = got0; base = base0; end
      1:       begin src = got1; base = base1; end
      default: begin src = got2; base = base2; end
    endcase
    q = {};
    for (int k = base; k < src.size(); k++) q.push_back(src[k]);
  endtask

  task automatic dut_out(input int i, output logic [63:0] we, run, done, err, cnt, addr, wdata);
    case (i)
      0: begin we = 64'(we0); run = 64'(run0); done = 64'(done0); err = 64'(err0);
               cnt = 64'(cnt0); addr = 64'(addr0); wdata = 64'(wdata0); end
      1: begin we = 64'(we1); run = 64'(run1); done = 64'(done1); err = 64'(err1);
               cnt = 64'(cnt1); addr = 64'(addr1); wdata = 64'(wdata1); end
      default: begin we = 64'(we2); run = 64'(run2); done = 64'(done2); err = 64'(err2);
               cnt = 64'(cnt2); addr = 64'(addr2); wdata = 64'(wdata2); end
    endcase
  endtask

  task automatic send(input byte_t b, input int gap);
    byte_valid = 1'b1;
    byte_in = b;
    hist.push_back(b);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    repeat (gap) begin
      byte_in = byte_t'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic rebase();
    hist.delete();
    base0 = got0.size();
    base1 = got1.size();
    base2 = got2.size();
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    reset_n = 1'b0;
    rebase();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic check_all(input string tag);
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      wr_t g[$];
      logic [63:0] we, run, done, err, cnt, addr, wdata;
      model(bpw_t[i], maxw_t[i], be_t[i]);
      get_q(i, g);
      dut_out(i, we, run, done, err, cnt, addr, wdata);
      check($sformatf("%s/d%0d cpu_run", tag, i), run, 64'(m_done));
      check($sformatf("%s/d%0d load_done", tag, i), done, 64'(m_done));
      check($sformatf("%s/d%0d err", tag, i), err, 64'(m_err));
      check($sformatf("%s/d%0d count", tag, i), cnt, 64'(m_cnt));
      check($sformatf("%s/d%0d n_writes", tag, i), 64'(g.size()), 64'(m_w.size()));
      for (int k = 0; k < m_w.size() && k < g.size(); k++) begin
        check($sformatf("%s/d%0d w%0d addr", tag, i, k), 64'(g[k].addr), 64'(m_w[k].addr));
        check($sformatf("%s/d%0d w%0d data", tag, i, k), 64'(g[k].data), 64'(m_w[k].data));
      end
      check($sformatf("%s/d%0d hold addr", tag, i), addr,
            (m_w.size() > 0) ? 64'(m_w[m_w.size()-1].addr) : 64'd0);
      check($sformatf("%s/d%0d hold data", tag, i), wdata,
            (m_w.size() > 0) ? 64'(m_w[m_w.size()-1].data) : 64'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic add_vec(input byte_t b[$], input int dut, input int n, input int la,
                         input longint ld, input bit err, input int cnt, input bit done);
    vec_t v;
    v.len = b.size();
    for (int k = 0; k < 16; k++) v.bytes[k] = (k < b.size()) ? b[k] : 8'h00;
    v.dut = dut; v.n_writes = n; v.last_addr = la; v.last_data = ld;
    v.err = err; v.count = cnt; v.done = done;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    add_vec('{8'hFE, 8'h13, 8'h00, 8'h00, 8'h00, 8'hFF}, 0, 1, 0, 64'h00000013, 0, 1, 1);
    add_vec('{8'hFE, 8'hFD, 8'hFF, 8'hFD, 8'hFE, 8'hFD, 8'hFD, 8'h01, 8'hFF},
            0, 1, 0, 64'h01FDFEFF, 0, 1, 1);
    add_vec('{8'hFE, 8'hAA, 8'hBB, 8'hFF}, 0, 1, 0, 64'h0000BBAA, 1, 1, 1);
    add_vec('{8'hFE, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
              8'h0A, 8'h0B, 8'h0C, 8'hFF}, 1, 2, 1, 64'h08070605, 1, 2, 1);
    add_vec('{8'hFE, 8'h11, 8'h22, 8'hFE, 8'h44, 8'h33, 8'h22, 8'h11, 8'hFF},
            0, 1, 0, 64'h11223344, 0, 1, 1);
    add_vec('{8'hFE, 8'h12, 8'h34, 8'hFF}, 2, 1, 0, 64'h1234, 0, 1, 1);

    // Reset state.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      logic [63:0] we, run, done, err, cnt, addr, wdata;
      dut_out(i, we, run, done, err, cnt, addr, wdata);
      check($sformatf("reset/d%0d outputs", i), {we[0], run[0], done[0], err[0], cnt, addr, wdata}, 64'd0);
    end

    // Table vectors.
    for (int v = 0; v < vecs.size(); v++) begin
      wr_t g[$];
      logic [63:0] we, run, done, err, cnt, addr, wdata;
      do_reset();
      for (int j = 0; j < vecs[v].len; j++) send(vecs[v].bytes[j], 0);
      check_all($sformatf("vec%0d", v));
      get_q(vecs[v].dut, g);
      dut_out(vecs[v].dut, we, run, done, err, cnt, addr, wdata);
      check($sformatf("vec%0d n_writes", v), 64'(g.size()), 64'(vecs[v].n_writes));
      if (g.size() > 0) begin
        check($sformatf("vec%0d last addr", v), 64'(g[g.size()-1].addr), 64'(vecs[v].last_addr));
        check($sformatf("vec%0d last data", v), 64'(g[g.size()-1].data), 64'(vecs[v].last_data));
      end
      check($sformatf("vec%0d err", v), err, 64'(vecs[v].err));
      check($sformatf("vec%0d count", v), cnt, 64'(vecs[v].count));
      check($sformatf("vec%0d cpu_run", v), run, 64'(vecs[v].done));
    end

    // Reload after DONE: CPU goes back into reset on the START edge.
    do_reset();
    send(8'hFE, 0); send(8'h13, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'hFF, 0);
    check("reload cpu_run before", 64'(run0), 64'd1);
    send(8'hFE, 0);
    check("reload cpu_run after", 64'(run0), 64'd0);
    check("reload load_done after", 64'(done0), 64'd0);
    check("reload count after", 64'(cnt0), 64'd0);
    check_all("reload");

    // Asynchronous reset mid-word.
    do_reset();
    send(8'hFE, 0); send(8'h12, 0); send(8'h34, 0); send(8'h56, 0);
    check_all("pre_async");
    #2;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      logic [63:0] we, run, done, err, cnt, addr, wdata;
      dut_out(i, we, run, done, err, cnt, addr, wdata);
      check($sformatf("async/d%0d outputs", i), {we[0], run[0], done[0], err[0], cnt, addr, wdata}, 64'd0);
    end
    rebase();
    @(posedge clk); #1;
    reset_n = 1'b1;
    send(8'h78, 0); send(8'hFF, 0);
    check_all("post_async");

    // Randomized frames with stuffing, gaps, noise, restarts and occasional missing END.
    do_reset();
    for (int f = 0; f < 60; f++) begin
      int n_noise = $urandom_range(0, 3);
      int n_data  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 12);
      for (int k = 0; k < n_noise; k++) begin
        byte_t b = byte_t'($urandom);
        if (b == 8'hFE) b = 8'h00;
        send(b, $urandom_range(0, 2));
      end
      send(8'hFE, $urandom_range(0, 2));
      for (int k = 0; k < n_data; k++) begin
        byte_t b = ($urandom_range(0, 4) == 0) ? byte_t'(8'hFD + $urandom_range(0, 2))
                                               : byte_t'($urandom);
        if (b >= 8'hFD || $urandom_range(0, 7) == 0) send(8'hFD, $urandom_range(0, 2));
        send(b, $urandom_range(0, 2));
      end
      if ($urandom_range(0, 9) != 0) send(8'hFF, $urandom_range(0, 2));
      check_all($sformatf("rand%0d", f));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
